// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the 32-point radix-2 MDC FFT: drives pipe_en, twiddle ROM addresses,
// commutator selects and output framing. Optional sticky protocol checker: FFT_CTRL_ERR_EN.
module fft_frame_ctrl #(
    parameter int N       = 32,
    parameter int LOG2N   = 5,
    parameter int OUT_LAT = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_sop,
    output logic       in_ready,
    output logic       pipe_en,
    output logic [3:0] rom_16_counter,
    output logic [2:0] rom_8_counter,
    output logic [5:0] state_code,
    output logic       out_valid,
    output logic       out_sop,
    output logic       err
);

    localparam int DRAIN_LEN = OUT_LAT + N / 2 - N;
    localparam int LAST_AGE  = OUT_LAT + N / 2 - 1;
    localparam int AW        = $clog2(LAST_AGE + 1);
    localparam int DW        = $clog2(DRAIN_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Handshake: a sample is taken on any cycle where in_valid and in_ready are both high;
    // in_ready depends only on the state register, never on in_valid.
    state_t           state_q, state_d;
    logic [LOG2N-1:0] t_q;
    logic [LOG2N-1:0] in_cnt_q;
    logic [DW-1:0]    drain_cnt_q;
    logic             parity_q;
    logic [1:0]       slot_act_q;
    logic [AW-1:0]    slot_age_q [2];

    logic accept;
    logic frame_start;
    logic pipe_en_c;
    logic to_idle;
    logic [1:0] slot_win;
    logic [1:0] slot_first;

    assign in_ready    = (state_q != DRAIN);
    assign accept      = in_valid & in_ready;
    assign frame_start = accept & in_sop & (in_cnt_q == '0);
    assign to_idle     = (state_q != IDLE) && (state_d == IDLE);

    always_comb begin
        state_d   = state_q;
        pipe_en_c = 1'b0;
        case (state_q)
            IDLE: begin
                pipe_en_c = frame_start;
                if (frame_start) state_d = RUN;
            end
            RUN: begin
                if (in_cnt_q != '0) begin
                    pipe_en_c = in_valid;
                end else begin
                    // Frame boundary: either the next frame starts or the pipeline drains.
                    pipe_en_c = 1'b1;
                    if (!frame_start) state_d = (DRAIN_LEN == 1) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                pipe_en_c = 1'b1;
                if (drain_cnt_q == DW'(DRAIN_LEN - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            t_q         <= '0;
            in_cnt_q    <= '0;
            drain_cnt_q <= '0;
            parity_q    <= 1'b0;
            slot_act_q  <= '0;
            for (int i = 0; i < 2; i++) slot_age_q[i] <= '0;
        end else begin
            state_q <= state_d;

            if (to_idle)        t_q <= '0;
            else if (pipe_en_c) t_q <= t_q + LOG2N'(1);

            if (frame_start)                    in_cnt_q <= LOG2N'(1);
            else if (accept && in_cnt_q != '0)  in_cnt_q <= in_cnt_q + LOG2N'(1);

            if (state_q == RUN && in_cnt_q == '0 && !frame_start)
                drain_cnt_q <= DW'(1);
            else if (state_q == DRAIN)
                drain_cnt_q <= (state_d == IDLE) ? '0 : drain_cnt_q + DW'(1);

            if (frame_start) parity_q <= ~parity_q;

            // Frames alternate between the two tracking slots, selected by the parity bit.
            for (int i = 0; i < 2; i++) begin
                if (frame_start && parity_q == 1'(i)) begin
                    slot_act_q[i] <= 1'b1;
                    slot_age_q[i] <= AW'(1);
                end else if (pipe_en_c && slot_act_q[i]) begin
                    if (slot_age_q[i] == AW'(LAST_AGE)) slot_act_q[i] <= 1'b0;
                    else                                slot_age_q[i] <= slot_age_q[i] + AW'(1);
                end
            end
        end
    end

    always_comb begin
        slot_win   = '0;
        slot_first = '0;
        for (int i = 0; i < 2; i++) begin
            slot_win[i]   = slot_act_q[i] && (slot_age_q[i] >= AW'(OUT_LAT))
                                          && (slot_age_q[i] <= AW'(LAST_AGE));
            slot_first[i] = slot_act_q[i] && (slot_age_q[i] == AW'(OUT_LAT));
        end
    end

    assign pipe_en   = pipe_en_c;
    assign out_valid = pipe_en_c & (|slot_win);
    assign out_sop   = pipe_en_c & (|slot_first);

    // The stage offsets (16, 24, 28, 30) are multiples of 2^(k+1) for the bit each stage
    // reads, so the subtractions vanish and the selects reduce to plain bits of t.
    assign rom_16_counter = t_q[3:0];
    assign rom_8_counter  = t_q[2:0];
    assign state_code     = {parity_q, t_q[0], t_q[1], t_q[2], t_q[3], t_q[4]};

`ifdef FFT_CTRL_ERR_EN
    logic err_q;
    logic err_set;

    assign err_set = (accept & in_sop & (in_cnt_q != '0))
                   | (in_valid & ~in_ready)
                   | ((state_q == IDLE) & in_valid & ~in_sop);

    always_ff @(posedge clk) begin
        if (rst)          err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: per-cycle behavioural model plus directed
// scenarios with hand-computed timing and decode literals.
module tb_fft_frame_ctrl;

    localparam int N         = 32;
    localparam int LOG2N     = 5;
    localparam int OUT_LAT   = 31;
    localparam int DRAIN_LEN = OUT_LAT + N / 2 - N;
    localparam int LAST      = OUT_LAT + N / 2 - 1;
`ifdef FFT_CTRL_ERR_EN
    localparam logic [31:0] ERR_EXP = 32'd1;
`else
    localparam logic [31:0] ERR_EXP = 32'd0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_sop = 1'b0;
    logic       in_ready;
    logic       pipe_en;
    logic [3:0] rom_16_counter;
    logic [2:0] rom_8_counter;
    logic [5:0] state_code;
    logic       out_valid;
    logic       out_sop;
    logic       err;

    fft_frame_ctrl #(.N(N), .LOG2N(LOG2N), .OUT_LAT(OUT_LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_sop         (in_sop),
        .in_ready       (in_ready),
        .pipe_en        (pipe_en),
        .rom_16_counter (rom_16_counter),
        .rom_8_counter  (rom_8_counter),
        .state_code     (state_code),
        .out_valid      (out_valid),
        .out_sop        (out_sop),
        .err            (err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    // exp_q holds the global pipe_en count at which each in-flight frame started.
    logic [31:0] exp_q[$];
    int m_P, m_p, m_left, m_drain, m_busy, m_par, m_err;

    always @(negedge clk) begin : model_cmp
        int t_e, age, ready_e, acc, start, pen, ov_e, sop_e, idle_e;
        logic [5:0] sc_e;
        if (rst) begin
            m_P = 0; m_p = 0; m_left = 0; m_drain = 0; m_busy = 0; m_par = 0; m_err = 0;
            exp_q.delete();
        end else begin
            while (exp_q.size() > 0 && (m_P - int'(exp_q[0])) > LAST) void'(exp_q.pop_front());
            ready_e = (m_drain == 0) ? 1 : 0;
            acc     = (in_valid && ready_e != 0) ? 1 : 0;
            start   = (acc != 0 && in_sop && m_left == 0) ? 1 : 0;
            idle_e  = (m_busy == 0) ? 1 : 0;
            if (m_left > 0)       pen = in_valid ? 1 : 0;
            else if (m_drain > 0) pen = 1;
            else if (m_busy != 0) pen = 1;
            else                  pen = start;

            t_e = m_p % N;
            ov_e = 0; sop_e = 0;
            foreach (exp_q[k]) begin
                age = m_P - int'(exp_q[k]);
                if (age >= OUT_LAT && age <= LAST) ov_e = 1;
                if (age == OUT_LAT) sop_e = 1;
            end
            if (pen == 0) begin ov_e = 0; sop_e = 0; end

            sc_e[0] = 1'((t_e / 16) % 2);
            sc_e[1] = 1'((((t_e - 16 + N) % N) / 8) % 2);
            sc_e[2] = 1'((((t_e - 24 + N) % N) / 4) % 2);
            sc_e[3] = 1'((((t_e - 28 + N) % N) / 2) % 2);
            sc_e[4] = 1'(((t_e - 30 + N) % N) % 2);
            sc_e[5] = 1'(m_par);

            chk("in_ready",   32'(in_ready),       ready_e);
            chk("pipe_en",    32'(pipe_en),        pen);
            chk("out_valid",  32'(out_valid),      ov_e);
            chk("out_sop",    32'(out_sop),        sop_e);
            chk("rom_16",     32'(rom_16_counter), t_e % 16);
            chk("rom_8",      32'(rom_8_counter),  ((t_e - 16 + N) % N) % 8);
            chk("state_code", 32'(state_code),     32'(sc_e));
            chk("err",        32'(err),            m_err);

`ifdef FFT_CTRL_ERR_EN
            if ((acc != 0 && in_sop && m_left != 0) || (in_valid && ready_e == 0) ||
                (idle_e != 0 && in_valid && !in_sop)) m_err = 1;
`endif
            if (start != 0) begin exp_q.push_back(32'(m_P)); m_par ^= 1; end
            if (m_left > 0) begin
                if (in_valid) m_left--;
            end else if (m_drain > 0) begin
                m_drain--;
                if (m_drain == 0) m_busy = 0;
            end else if (m_busy != 0) begin
                if (start != 0) m_left = N - 1;
                else begin
                    m_drain = DRAIN_LEN - 1;
                    if (m_drain == 0) m_busy = 0;
                end
            end else if (start != 0) begin
                m_busy = 1; m_left = N - 1;
            end
            if (pen != 0) begin m_P++; m_p++; end
            if (m_busy == 0) m_p = 0;
        end
    end

    // ---------------- event log for literal timing checks ----------------
    int ov_first, ov_last, ov_cnt, sop_first, sop_cnt, pe_last, rdy_low_first, rdy_low_last;

    task automatic clear_log();
        ov_first = -1; ov_last = -1; ov_cnt = 0; sop_first = -1; sop_cnt = 0;
        pe_last = -1; rdy_low_first = -1; rdy_low_last = -1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid === 1'b1) begin
                if (ov_first < 0) ov_first = cyc;
                ov_last = cyc; ov_cnt++;
            end
            if (out_sop === 1'b1) begin
                if (sop_first < 0) sop_first = cyc;
                sop_cnt++;
            end
            if (pipe_en === 1'b1) pe_last = cyc;
            if (in_ready === 1'b0) begin
                if (rdy_low_first < 0) rdy_low_first = cyc;
                rdy_low_last = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic s);
        in_valid = v;
        in_sop   = s;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    // One contiguous frame; t=20 decode and frame timing pinned with literals.
    task automatic run_single(input string tag);
        int s;
        clear_log();
        s = cyc;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_sop   = (i == 0);
            if (i == 20) begin
                #2;
                chk({tag, "_t20_rom16"}, 32'(rom_16_counter), 4);
                chk({tag, "_t20_rom8"},  32'(rom_8_counter),  4);
                chk({tag, "_t20_sc"},    32'(state_code[4:0]), 32'b00101);
            end
            @(posedge clk); #1;
        end
        idle_cycles(24);
        chk({tag, "_ov_first"},  ov_first - s, 31);
        chk({tag, "_ov_last"},   ov_last - s, 46);
        chk({tag, "_ov_cnt"},    ov_cnt, 16);
        chk({tag, "_sop_first"}, sop_first - s, 31);
        chk({tag, "_sop_cnt"},   sop_cnt, 1);
        chk({tag, "_pe_last"},   pe_last - s, 46);
        chk({tag, "_rdy_low"},   rdy_low_last - s, 46);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : main
        int s;
        do_reset();
        #2;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_pipe_en",  32'(pipe_en), 0);
        chk("rst_sc",       32'(state_code), 0);
        @(posedge clk); #1;

        // single frame
        run_single("s1");

        // back-to-back frames
        do_reset();
        clear_log();
        s = cyc;
        for (int i = 0; i < 2 * N; i++) begin
            in_valid = 1'b1;
            in_sop   = (i == 0 || i == N);
            if (i == N)     begin #2; chk("b2b_par_at32", 32'(state_code[5]), 1); end
            if (i == N + 1) begin #2; chk("b2b_par_at33", 32'(state_code[5]), 0); end
            @(posedge clk); #1;
        end
        idle_cycles(24);
        chk("b2b_ov_first", ov_first - s, 31);
        chk("b2b_ov_last",  ov_last - s, 78);
        chk("b2b_ov_cnt",   ov_cnt, 32);
        chk("b2b_sop_cnt",  sop_cnt, 2);
        chk("b2b_rdy_low",  rdy_low_first - s, 65);
        chk("b2b_pe_last",  pe_last - s, 78);

        // 5-cycle gap after sample 10
        do_reset();
        clear_log();
        s = cyc;
        for (int i = 0; i < 11; i++) drive(1'b1, i == 0);
        for (int g = 0; g < 5; g++) begin
            in_valid = 1'b0; in_sop = 1'b0;
            #2;
            chk("gap_pipe_en", 32'(pipe_en), 0);
            chk("gap_rom16",   32'(rom_16_counter), 11);
            chk("gap_sc",      32'(state_code), 32'b111010);
            @(posedge clk); #1;
        end
        for (int i = 11; i < N; i++) drive(1'b1, 1'b0);
        idle_cycles(24);
        chk("gap_ov_first", ov_first - s, 36);
        chk("gap_ov_last",  ov_last - s, 51);
        chk("gap_ov_cnt",   ov_cnt, 16);

        // reset at sample 20, then a clean frame
        do_reset();
        for (int i = 0; i < 20; i++) drive(1'b1, i == 0);
        in_valid = 1'b1; in_sop = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        #2;
        chk("mrst_pipe_en",   32'(pipe_en), 0);
        chk("mrst_out_valid", 32'(out_valid), 0);
        chk("mrst_in_ready",  32'(in_ready), 1);
        chk("mrst_rom16",     32'(rom_16_counter), 0);
        chk("mrst_sc",        32'(state_code), 0);
        chk("mrst_err",       32'(err), 0);
        @(posedge clk); #1;
        run_single("s4");

        // mid-frame in_sop at sample 7
        do_reset();
        clear_log();
        s = cyc;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_sop   = (i == 0 || i == 7);
            if (i == 7) begin #2; chk("sop7_err_before", 32'(err), 0); end
            if (i == 8) begin #2; chk("sop7_err_after", 32'(err), ERR_EXP); end
            @(posedge clk); #1;
        end
        idle_cycles(24);
        chk("sop7_ov_first", ov_first - s, 31);
        chk("sop7_ov_cnt",   ov_cnt, 16);
        chk("sop7_err_hold", 32'(err), ERR_EXP);

        // stray valid in IDLE, then valid held through the drain
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
        #2;
        chk("stray_err", 32'(err), ERR_EXP);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) drive(1'b1, i == 0);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0);
        idle_cycles(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
